// File: rtl/serial_pw_rx.sv
// Pulse-width-coded serial receiver: synchronizes the line, measures high pulse widths,
// assembles MSB-first words and buffers them in a FIFO. Define SERIAL_PW_RX_STATS_EN for the error counter.
module serial_pw_rx #(
  parameter int WORD_W     = 8,
  parameter int THRESH     = 8,
  parameter int MIN_PULSE  = 2,
  parameter int MAX_PULSE  = 15,
  parameter int IDLE_TO    = 48,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_err,
  output logic [7:0]        err_cnt
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int GW = $clog2(IDLE_TO + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0]    THR_W    = 5'(THRESH);
  localparam logic [4:0]    MIN_W    = 5'(MIN_PULSE);
  localparam logic [4:0]    MAX_W    = 5'(MAX_PULSE);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_TO - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic              sync1_q, s_q, s_prev_q;
  logic [1:0]        settle_q, settle_d;
  logic [1:0]        state_q, state_d;
  logic [4:0]        w_q, w_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              done_q, done_d;
  logic              ferr_ev;

  // After reset the line is trusted only once the synchronizer and s_prev hold real samples;
  // a line found already high is swallowed through FAULT without flagging an error.
  always_comb begin
    settle_d = (settle_q == 2'd3) ? 2'd3 : settle_q + 2'd1;
    state_d  = state_q;
    w_d      = w_q;
    gap_d    = gap_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    ferr_ev  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (settle_q == 2'd3 && s_q) begin
          if (s_prev_q) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_HIGH;
            w_d     = 5'd1;
          end
        end
      end
      ST_GAP: begin
        if (s_q) begin
          state_d = ST_HIGH;
          w_d     = 5'd1;
        end else if (gap_q >= GAP_LAST) begin
          state_d  = ST_IDLE;
          bitcnt_d = '0;
          ferr_ev  = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_HIGH: begin
        if (s_q) begin
          if (w_q >= MAX_W) begin
            state_d  = ST_FAULT;
            bitcnt_d = '0;
            ferr_ev  = 1'b1;
          end else begin
            w_d = (w_q == 5'd31) ? 5'd31 : w_q + 5'd1;
          end
        end else if (w_q < MIN_W) begin
          ferr_ev = 1'b1;
          gap_d   = GW'(1);
          state_d = (bitcnt_q == '0) ? ST_IDLE : ST_GAP;
        end else begin
          shift_d = WORD_W'({shift_q, (w_q >= THR_W)});
          gap_d   = GW'(1);
          if (bitcnt_q == LAST_BIT) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            done_d   = 1'b1;
          end else begin
            state_d  = ST_GAP;
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      default: begin
        if (!s_q) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
      settle_q <= 2'd0;
      state_q  <= ST_IDLE;
      w_q      <= '0;
      gap_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= serial_in;
      s_q      <= sync1_q;
      s_prev_q <= s_q;
      settle_q <= settle_d;
      state_q  <= state_d;
      w_q      <= w_d;
      gap_q    <= gap_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

  // The completed word sits in shift_q for the cycle after completion and is pushed from there.
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              full, pop, push_ok, drop;

  assign rx_valid = (cnt_q != '0);
  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = done_q && (!full || pop);
  assign drop     = done_q && full && !pop;
  assign rx_data  = rx_valid ? mem_q[rd_q] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      overflow  <= drop    | (overflow  & ~clr_err);
      frame_err <= ferr_ev | (frame_err & ~clr_err);
    end
  end

`ifdef SERIAL_PW_RX_STATS_EN
  logic [7:0] err_q;
  logic [8:0] err_sum;

  always_comb begin
    err_sum = (clr_err ? 9'd0 : {1'b0, err_q}) + 9'(ferr_ev) + 9'(drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 8'd0;
    else        err_q <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_serial_pw_rx.sv
// Directed bench for serial_pw_rx: 16-cycle bit slots, 4-cycle pulse = 0, 12-cycle pulse = 1.
module tb_serial_pw_rx;

  logic       clk = 1'b0;
  logic       rst_n, serial_in, rx_ready, clr_err;
  logic [7:0] rx_data, err_cnt;
  logic       rx_valid, overflow, frame_err;
  int         checks = 0;
  int         errors = 0;

`ifdef SERIAL_PW_RX_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  serial_pw_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial_in = 1'b1;
    repeat (b ? 12 : 4) @(negedge clk);
    serial_in = 1'b0;
    repeat (b ? 4 : 12) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[7-i]);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    serial_in = 1'b0;
    rx_ready  = 1'b0;
    clr_err   = 1'b0;
    rst_n     = 1'b0;
    idle(3);
    chk("reset_valid", 16'(rx_valid), 16'h0);
    chk("reset_data", 16'(rx_data), 16'h0);
    chk("reset_ovf", 16'(overflow), 16'h0);
    chk("reset_ferr", 16'(frame_err), 16'h0);
    chk("reset_errcnt", 16'(err_cnt), 16'h0);
    rst_n = 1'b1;
    idle(4);

    // 0xA5 with latency check on the final falling edge
    send_bits(8'hA5, 7);
    serial_in = 1'b1;
    repeat (12) @(negedge clk);
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("lat_e2_valid", 16'(rx_valid), 16'h0);
    @(posedge clk);
    #1 chk("lat_e3_valid", 16'(rx_valid), 16'h1);
    idle(4);
    chk("a5_data", 16'(rx_data), 16'hA5);
    chk("a5_ferr", 16'(frame_err), 16'h0);
    chk("a5_ovf", 16'(overflow), 16'h0);
    idle(5);
    chk("a5_stable", 16'(rx_data), 16'hA5);
    pop_one();
    chk("a5_popped", 16'(rx_valid), 16'h0);

    // overflow: five words into a four-deep FIFO
    for (int k = 1; k <= 5; k++) send_bits(8'(k), 8);
    idle(4);
    chk("ovf_flag", 16'(overflow), 16'h1);
    chk("ovf_ferr", 16'(frame_err), 16'h0);
    chk("ovf_errcnt", 16'(err_cnt), 16'(STATS));
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", 16'(rx_valid), 16'h1);
      chk("drain_data", 16'(rx_data), 16'(k));
      pop_one();
    end
    chk("drain_empty", 16'(rx_valid), 16'h0);
    clear_flags();
    chk("clr_ovf", 16'(overflow), 16'h0);
    chk("clr_errcnt", 16'(err_cnt), 16'h0);

    // 1-cycle glitch inside 0x3C
    send_bits(8'h3C, 4);
    serial_in = 1'b1;
    @(negedge clk);
    serial_in = 1'b0;
    idle(4);
    send_bits(8'hC0, 4);
    idle(4);
    chk("glitch_valid", 16'(rx_valid), 16'h1);
    chk("glitch_data", 16'(rx_data), 16'h3C);
    chk("glitch_ferr", 16'(frame_err), 16'h1);
    chk("glitch_errcnt", 16'(err_cnt), 16'(STATS));
    pop_one();
    clear_flags();
    chk("glitch_clr", 16'(frame_err), 16'h0);

    // overlong pulse after 3 bits, then 0x81
    send_bits(8'hA0, 3);
    serial_in = 1'b1;
    idle(20);
    serial_in = 1'b0;
    idle(8);
    send_bits(8'h81, 8);
    idle(4);
    chk("long_data", 16'(rx_data), 16'h81);
    chk("long_ferr", 16'(frame_err), 16'h1);
    chk("long_errcnt", 16'(err_cnt), 16'(STATS));
    pop_one();
    chk("long_single", 16'(rx_valid), 16'h0);
    clear_flags();

    // 4 bits then a long idle, then 0xFF
    send_bits(8'hF0, 4);
    idle(60);
    send_bits(8'hFF, 8);
    idle(4);
    chk("gap_data", 16'(rx_data), 16'hFF);
    chk("gap_ferr", 16'(frame_err), 16'h1);
    chk("gap_errcnt", 16'(err_cnt), 16'(STATS));
    pop_one();
    chk("gap_single", 16'(rx_valid), 16'h0);
    clear_flags();

    // reset mid-pulse with a word still buffered, then 0x5A
    send_bits(8'h77, 8);
    send_bits(8'h50, 4);
    serial_in = 1'b1;
    idle(5);
    rst_n = 1'b0;
    #1 chk("rst_valid", 16'(rx_valid), 16'h0);
    chk("rst_data", 16'(rx_data), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    serial_in = 1'b0;
    idle(12);
    send_bits(8'h5A, 8);
    idle(4);
    chk("post_rst_data", 16'(rx_data), 16'h5A);
    chk("post_rst_ferr", 16'(frame_err), 16'h0);
    chk("post_rst_ovf", 16'(overflow), 16'h0);
    chk("post_rst_errcnt", 16'(err_cnt), 16'h0);
    pop_one();
    chk("post_rst_single", 16'(rx_valid), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
